// File: rtl/l2_tag_lookup.sv
// Per-set tag lookup and true-LRU allocation stage for the L2 cache model.
// One request in flight: IDLE -> LOOKUP (one cycle) -> RESPOND; snoop invalidations complete in IDLE.
module l2_tag_lookup #(
  parameter int unsigned tagBits   = 12,
  parameter int unsigned indexBits = 4,
  parameter int unsigned ways      = 4,
  localparam int unsigned wayBits  = $clog2(ways)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [tagBits-1:0]   req_tag,
  input  logic [indexBits-1:0] req_index,
  input  logic                 req_write,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic [wayBits-1:0]   rsp_way,
  output logic                 rsp_evict_valid,
  output logic [tagBits-1:0]   rsp_evict_tag,
  input  logic                 inv_valid,
  output logic                 inv_ready,
  input  logic [tagBits-1:0]   inv_tag,
  input  logic [indexBits-1:0] inv_index
);

  localparam int unsigned sets = 2 ** indexBits;
  localparam logic [wayBits-1:0] oldestAge = wayBits'(ways - 1);

  typedef enum logic [1:0] {StIdle, StLookup, StRespond} state_e;
  state_e stateQ, stateD;

  logic [tagBits-1:0] tagQ   [sets][ways];
  logic [wayBits-1:0] ageQ   [sets][ways];
  logic [ways-1:0]    validQ [sets];
  logic [ways-1:0]    dirtyQ [sets];

  logic [tagBits-1:0]   capTagQ;
  logic [indexBits-1:0] capIndexQ;
  logic                 capWriteQ;

  logic                 rspHitQ;
  logic [wayBits-1:0]   rspWayQ;
  logic                 rspEvictValidQ;
  logic [tagBits-1:0]   rspEvictTagQ;

  logic reqFire, invFire;

  assign req_ready = (stateQ == StIdle) && !inv_valid;
  assign inv_ready = (stateQ == StIdle);
  assign reqFire   = req_valid && req_ready;
  assign invFire   = inv_valid && inv_ready;

  assign rsp_valid       = (stateQ == StRespond);
  assign rsp_hit         = rspHitQ;
  assign rsp_way         = rspWayQ;
  assign rsp_evict_valid = rspEvictValidQ;
  assign rsp_evict_tag   = rspEvictTagQ;

  // Lookup on the captured set: hit way, lowest free way, and the oldest way.
  logic               lookupHit, freeFound, evictNeeded;
  logic [wayBits-1:0] hitWay, freeWay, lruWay, accessWay, oldAge;
  logic [wayBits-1:0] newAge [ways];
  logic [ways-1:0]    invMatch;

  always_comb begin
    lookupHit = 1'b0;
    hitWay    = '0;
    freeFound = 1'b0;
    freeWay   = '0;
    lruWay    = '0;
    for (int unsigned w = 0; w < ways; w++) begin
      if (validQ[capIndexQ][w] && (tagQ[capIndexQ][w] == capTagQ) && !lookupHit) begin
        lookupHit = 1'b1;
        hitWay    = wayBits'(w);
      end
      if (!validQ[capIndexQ][w] && !freeFound) begin
        freeFound = 1'b1;
        freeWay   = wayBits'(w);
      end
      if (ageQ[capIndexQ][w] == oldestAge) begin
        lruWay = wayBits'(w);
      end
    end
    accessWay   = lookupHit ? hitWay : (freeFound ? freeWay : lruWay);
    oldAge      = ageQ[capIndexQ][accessWay];
    evictNeeded = !lookupHit && validQ[capIndexQ][accessWay] && dirtyQ[capIndexQ][accessWay];
    // Ages younger than the accessed way step back one; the set stays a permutation.
    for (int unsigned w = 0; w < ways; w++) begin
      if (wayBits'(w) == accessWay) begin
        newAge[w] = '0;
      end else if (ageQ[capIndexQ][w] < oldAge) begin
        newAge[w] = ageQ[capIndexQ][w] + 1'b1;
      end else begin
        newAge[w] = ageQ[capIndexQ][w];
      end
    end
  end

  always_comb begin
    invMatch = '0;
    for (int unsigned w = 0; w < ways; w++) begin
      invMatch[w] = validQ[inv_index][w] && (tagQ[inv_index][w] == inv_tag);
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:    if (reqFire) stateD = StLookup;
      StLookup:  stateD = StRespond;
      StRespond: if (rsp_ready) stateD = StIdle;
      default:   stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ         <= StIdle;
      capTagQ        <= '0;
      capIndexQ      <= '0;
      capWriteQ      <= 1'b0;
      rspHitQ        <= 1'b0;
      rspWayQ        <= '0;
      rspEvictValidQ <= 1'b0;
      rspEvictTagQ   <= '0;
    end else begin
      stateQ <= stateD;
      if (reqFire) begin
        capTagQ   <= req_tag;
        capIndexQ <= req_index;
        capWriteQ <= req_write;
      end
      if (stateQ == StLookup) begin
        rspHitQ        <= lookupHit;
        rspWayQ        <= accessWay;
        rspEvictValidQ <= evictNeeded;
        rspEvictTagQ   <= evictNeeded ? tagQ[capIndexQ][accessWay] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < sets; s++) begin
        validQ[s] <= '0;
        dirtyQ[s] <= '0;
        for (int unsigned w = 0; w < ways; w++) begin
          tagQ[s][w] <= '0;
          ageQ[s][w] <= wayBits'(w);
        end
      end
    end else if (invFire) begin
      validQ[inv_index] <= validQ[inv_index] & ~invMatch;
      dirtyQ[inv_index] <= dirtyQ[inv_index] & ~invMatch;
    end else if (stateQ == StLookup) begin
      for (int unsigned w = 0; w < ways; w++) begin
        ageQ[capIndexQ][w] <= newAge[w];
      end
      validQ[capIndexQ][accessWay] <= 1'b1;
      if (lookupHit) begin
        if (capWriteQ) dirtyQ[capIndexQ][accessWay] <= 1'b1;
      end else begin
        tagQ[capIndexQ][accessWay]   <= capTagQ;
        dirtyQ[capIndexQ][accessWay] <= capWriteQ;
      end
    end
  end

endmodule
